// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - fractional baud-rate generator producing oversample/baud strobes and a baud clock
module baud_tick_gen #(
  parameter int CNT_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 54,
  parameter int DEF_FRAC = 4
) (
  input  logic              CLK100MHZ,
  input  logic              resetn,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              baud_clk,
  output logic              upd_pend,
  output logic              div_err
);

  localparam int OS_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVS / 2 - 1);

  logic [CNT_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d, cnt_q, cnt_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d, acc_q, acc_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic              ext_q, ext_d, upd_pend_q, upd_pend_d;
  logic              os_tick_q, os_tick_d, baud_tick_q, baud_tick_d, baud_clk_q, baud_clk_d;
  logic              run, hit, apply;
  logic [CNT_W:0]    term;

  assign div_err = (act_int_q < CNT_W'(2));
  assign run     = en & ~div_err;
  // One bit wider than the counter so act_int - 1 + ext never wraps.
  assign term    = {1'b0, act_int_q} + {{CNT_W{1'b0}}, ext_q} - {{CNT_W{1'b0}}, 1'b1};
  assign hit     = run & ({1'b0, cnt_q} == term);
  assign apply   = upd_pend_q & (~run | hit);

  always_comb begin
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    upd_pend_d  = upd_pend_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ext_d       = ext_q;
    os_cnt_d    = os_cnt_q;
    baud_clk_d  = baud_clk_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;

    if (!run) begin
      cnt_d      = '0;
      acc_d      = '0;
      ext_d      = 1'b0;
      os_cnt_d   = '0;
      baud_clk_d = 1'b0;
    end else if (hit) begin
      cnt_d          = '0;
      os_tick_d      = 1'b1;
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
      os_cnt_d       = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      baud_tick_d    = (os_cnt_q == OS_LAST);
      if (os_cnt_q == OS_HALF) baud_clk_d = 1'b1;
      if (os_cnt_q == OS_LAST) baud_clk_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // os_cnt and baud_clk are left alone so the baud phase survives a divisor change.
    if (apply) begin
      act_int_d  = pend_int_q;
      act_frac_d = pend_frac_q;
      upd_pend_d = 1'b0;
      acc_d      = '0;
      ext_d      = 1'b0;
    end

    if (load) begin
      pend_int_d  = div_int;
      pend_frac_d = div_frac;
      upd_pend_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      act_int_q   <= CNT_W'(DEF_INT);
      act_frac_q  <= FRAC_W'(DEF_FRAC);
      pend_int_q  <= CNT_W'(DEF_INT);
      pend_frac_q <= FRAC_W'(DEF_FRAC);
      upd_pend_q  <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ext_q       <= 1'b0;
      os_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      baud_clk_q  <= 1'b0;
    end else begin
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      upd_pend_q  <= upd_pend_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ext_q       <= ext_d;
      os_cnt_q    <= os_cnt_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      baud_clk_q  <= baud_clk_d;
    end
  end

  assign os_tick   = os_tick_q;
  assign baud_tick = baud_tick_q;
  assign baud_clk  = baud_clk_q;
  assign upd_pend  = upd_pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - randomized bench for baud_tick_gen against a closed-form tick-time model
module tb_baud_tick_gen;

  localparam int CNT_W = 16, FRAC_W = 4, OVS = 16, DEF_INT = 54, DEF_FRAC = 4;

  logic              CLK100MHZ = 1'b0;
  logic              resetn    = 1'b0;
  logic              en        = 1'b0;
  logic [CNT_W-1:0]  div_int   = '0;
  logic [FRAC_W-1:0] div_frac  = '0;
  logic              load      = 1'b0;
  logic              os_tick, baud_tick, baud_clk, upd_pend, div_err;

  baud_tick_gen #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_INT(DEF_INT), .DEF_FRAC(DEF_FRAC)) dut (
    .CLK100MHZ(CLK100MHZ), .resetn(resetn), .en(en), .div_int(div_int), .div_frac(div_frac),
    .load(load), .os_tick(os_tick), .baud_tick(baud_tick), .baud_clk(baud_clk),
    .upd_pend(upd_pend), .div_err(div_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: within a segment started at edge `origin` with divisor I + F/2^FRAC_W,
  // the k-th oversample tick lands on edge origin + k*I + floor((k-1)*F / 2^FRAC_W).
  int t = 0, origin = 0, k = 0, g = 0;
  int m_int, m_frac, p_int, p_frac;
  bit m_upd, e_os, e_bt, e_clk;

  task automatic model_reset();
    m_int = DEF_INT; m_frac = DEF_FRAC; p_int = DEF_INT; p_frac = DEF_FRAC;
    m_upd = 0; origin = t; k = 0; g = 0; e_os = 0; e_bt = 0; e_clk = 0;
  endtask

  task automatic model_step();
    bit run, tk;
    int nxt;
    t++;
    run  = en && (m_int >= 2);
    tk   = 0;
    e_bt = 0;
    if (!run) begin
      origin = t; k = 0; g = 0;
    end else begin
      nxt = origin + (k + 1) * m_int + ((k * m_frac) >> FRAC_W);
      if (t == nxt) begin
        tk = 1; k++;
        e_bt = (g == OVS - 1);
        g = (g + 1) % OVS;
      end
    end
    if (m_upd && (!run || tk)) begin
      m_int = p_int; m_frac = p_frac; m_upd = 0;
      if (tk) begin origin = t; k = 0; end
    end
    if (load) begin p_int = int'(div_int); p_frac = int'(div_frac); m_upd = 1; end
    e_os  = tk;
    e_clk = run && (g >= OVS / 2);
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    model_step();
    @(negedge CLK100MHZ);
    check("os_tick", os_tick, e_os);
    check("baud_tick", baud_tick, e_bt);
    check("baud_clk", baud_clk, e_clk);
    check("upd_pend", upd_pend, m_upd);
    check("div_err", div_err, m_int < 2);
  endtask

  task automatic do_load(input int di, input int df);
    div_int = CNT_W'(di); div_frac = FRAC_W'(df); load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_os_tick"}, os_tick, 0);
    check({tag, "_baud_tick"}, baud_tick, 0);
    check({tag, "_baud_clk"}, baud_clk, 0);
    check({tag, "_upd_pend"}, upd_pend, 0);
    check({tag, "_div_err"}, div_err, 0);
  endtask

  // Runs the default divisor and times the first two baud strobes from the enable point.
  task automatic default_baud_timing(input string tag);
    int t0, b1, b2, nbt;
    t0 = t; b1 = -1; b2 = -1; nbt = 0;
    en = 1'b1;
    repeat (1800) begin
      step();
      if (baud_tick) begin
        if (nbt == 0) b1 = t - t0;
        else if (nbt == 1) b2 = t - t0;
        nbt++;
      end
    end
    check({tag, "_first_baud"}, b1, 867);
    check({tag, "_baud_gap"}, b2 - b1, 868);
  endtask

  initial begin
    model_reset();
    repeat (3) begin @(posedge CLK100MHZ); t++; end
    @(negedge CLK100MHZ);
    check_reset_vals("reset");
    resetn = 1'b1;
    model_reset();

    default_baud_timing("dflt");

    en = 1'b0; step();
    do_load(4, 0);
    repeat (3) step();
    en = 1'b1;
    repeat (200) step();

    do_load(10, 0);
    repeat (23) step();
    do_load(6, 0);
    repeat (120) step();

    do_load(8, 0);
    repeat (12) step();
    en = 1'b0;
    repeat (6) step();
    en = 1'b1;
    repeat (200) step();

    do_load(1, 0);
    repeat (60) step();
    check("halted_err", div_err, 1);
    do_load(3, 0);
    repeat (100) step();

    repeat (15000) begin
      if ($urandom_range(0, 399) == 0) en = ~en;
      if ($urandom_range(0, 119) == 0) begin
        div_int  = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 1)) : CNT_W'($urandom_range(2, 12));
        div_frac = FRAC_W'($urandom_range(0, 15));
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;

    en = 1'b1;
    do_load(3, 0);
    repeat (40) step();
    do_load(7, 5);
    #2 resetn = 1'b0;
    #1 check_reset_vals("async");
    en = 1'b0;
    @(posedge CLK100MHZ); t++;
    @(negedge CLK100MHZ);
    check_reset_vals("held");
    #2 resetn = 1'b1;
    model_reset();
    default_baud_timing("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
